// File: rtl/neuron_accumulator.sv
// Neuron weighted-sum accumulator: z = bias + sum(x_i * w_i).
// Two-stage FP pipeline (multiply, accumulate) under a 4-state FSM.
module neuron_accumulator #(
   parameter int N_IN = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_x,
   input  logic [31:0] in_w,
   input  logic [31:0] bias,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_z,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

   localparam logic [4:0] LAST = 5'(N_IN);

   state_t      state;
   logic [4:0]  cnt;
   logic [4:0]  cnt_inc;
   logic [31:0] acc;
   logic [31:0] prod_reg;
   logic        prod_v;
   logic        take;
   logic [31:0] sum;

   // Single-precision multiply, round-to-nearest-even.
   // Zero or subnormal operands flush the product to +0.
   function automatic logic [31:0] fp_mul(
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic [47:0] p;
      logic [23:0] m;
      logic [24:0] mr;
      logic        g;
      logic        st;
      logic        sgn;
      int          ex;
      sgn = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
         return 32'h0;
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      ex = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         m  = p[47:24];
         g  = p[23];
         st = |p[22:0];
         ex = ex + 1;
      end else begin
         m  = p[46:23];
         g  = p[22];
         st = |p[21:0];
      end
      mr = {1'b0, m} + {24'd0, g & (st | m[0])};
      if (mr[24]) begin
         mr = {1'b0, mr[24:1]};
         ex = ex + 1;
      end
      if (ex <= 0)
         return {sgn, 31'd0};
      if (ex >= 255)
         return {sgn, 8'hFF, 23'd0};
      return {sgn, ex[7:0], mr[22:0]};
   endfunction

   // Single-precision add, round-to-nearest-even.
   // Subnormals read as zero; exact cancellation gives +0.
   function automatic logic [31:0] fp_add(
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic [31:0] x;
      logic [31:0] y;
      logic [26:0] mx;
      logic [26:0] my;
      logic [27:0] s;
      logic [24:0] mr;
      logic        rnd;
      int          ex;
      int          d;
      x = a;
      y = b;
      if (a[30:0] < b[30:0]) begin
         x = b;
         y = a;
      end
      mx = (x[30:23] == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
      my = (y[30:23] == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
      ex = int'(x[30:23]);
      d  = ex - int'(y[30:23]);
      for (int i = 0; i < 27; i++)
         if (i < d)
            my = {1'b0, my[26:1]} | {26'd0, my[0]};
      if (x[31] == y[31])
         s = {1'b0, mx} + {1'b0, my};
      else
         s = {1'b0, mx} - {1'b0, my};
      if (s == 28'd0)
         return 32'h0;
      if (s[27]) begin
         s  = {1'b0, s[27:2], s[1] | s[0]};
         ex = ex + 1;
      end else begin
         for (int i = 0; i < 26; i++)
            if (!s[26]) begin
               s  = s << 1;
               ex = ex - 1;
            end
      end
      rnd = s[2] & (s[1] | s[0] | s[3]);
      mr  = {1'b0, s[26:3]} + {24'd0, rnd};
      if (mr[24]) begin
         mr = {1'b0, mr[24:1]};
         ex = ex + 1;
      end
      if (ex <= 0)
         return {x[31], 31'd0};
      if (ex >= 255)
         return {x[31], 8'hFF, 23'd0};
      return {x[31], ex[7:0], mr[22:0]};
   endfunction

   assign in_ready = (state == IDLE) || (state == ACCUM);
   assign busy     = (state != IDLE);
   assign take     = in_valid && in_ready;
   assign cnt_inc  = cnt + 5'd1;
   assign sum      = fp_add(acc, prod_reg);

   // Product stage: one multiply per accepted beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prod_reg <= 32'h0;
         prod_v   <= 1'b0;
      end else if (take) begin
         prod_reg <= fp_mul(in_x, in_w);
         prod_v   <= 1'b1;
      end else begin
         prod_v   <= 1'b0;
      end
   end

   // Sequencer, accumulator and registered result handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 5'd0;
         acc       <= 32'h0;
         out_z     <= 32'h0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (take) begin
                  cnt   <= 5'd1;
                  acc   <= bias;
                  state <= (LAST == 5'd1) ? DRAIN : ACCUM;
               end
            end
            ACCUM: begin
               if (prod_v)
                  acc <= sum;
               if (take) begin
                  cnt <= cnt_inc;
                  if (cnt_inc == LAST)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (prod_v)
                  acc <= sum;
               out_z     <= sum;
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= 32'h0;
                  cnt       <= 5'd0;
                  state     <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator: integer-valued vectors are exact in
// single precision, so z is modelled with plain integer arithmetic.
module tb_neuron_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iv [2];
   logic        ordy [2];
   logic [31:0] ix [2];
   logic [31:0] iw [2];
   logic [31:0] ib [2];
   logic        ir [2];
   logic        ov [2];
   logic        bz [2];
   logic [31:0] oz [2];

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          post_cnt [2] = '{0, 0};
   int          done_cnt [2] = '{0, 0};
   int          seen_id [2] = '{0, 0};
   int          beats [2] = '{0, 0};
   int          exp_cyc [2] = '{0, 0};
   logic [31:0] exp_z [2];
   int          vb;
   int          vx [16];
   int          vw [16];

   neuron_accumulator #(.N_IN(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[0]), .in_ready(ir[0]),
      .in_x(ix[0]), .in_w(iw[0]), .bias(ib[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]),
      .out_z(oz[0]), .busy(bz[0])
   );

   neuron_accumulator #(.N_IN(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[1]), .in_ready(ir[1]),
      .in_x(ix[1]), .in_w(iw[1]), .bias(ib[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]),
      .out_z(oz[1]), .busy(bz[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   function automatic logic [31:0] to_fp(input int v);
      int m;
      int p;
      logic [31:0] r;
      if (v == 0) return 32'h0;
      m = (v < 0) ? -v : v;
      p = 0;
      for (int i = 0; i < 24; i++)
         if (m >= (1 << i)) p = i;
      r[31] = (v < 0);
      r[30:23] = 8'(127 + p);
      r[22:0] = 23'((m << (23 - p)) & 32'h7FFFFF);
      return r;
   endfunction

   function automatic logic [31:0] model_z(input int n);
      int s;
      s = vb;
      for (int i = 0; i < n; i++) s += vx[i] * vw[i];
      return to_fp(s);
   endfunction

   function automatic bit pending(input int d);
      return post_cnt[d] != done_cnt[d];
   endfunction

   // Compare process: handshake, busy, latency and z every cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("in_ready%0d", d),
                {31'd0, ir[d]}, {31'd0, !pending(d)});
            chk($sformatf("busy%0d", d), {31'd0, bz[d]},
                {31'd0, pending(d) || beats[d] != 0});
            if (ov[d]) begin
               chk($sformatf("spurious_valid%0d", d),
                   {31'd0, ov[d]}, {31'd0, pending(d)});
               if (pending(d)) begin
                  chk($sformatf("out_z%0d", d), oz[d], exp_z[d]);
                  if (seen_id[d] != post_cnt[d]) begin
                     chk($sformatf("latency%0d", d), cyc, exp_cyc[d]);
                     seen_id[d] <= post_cnt[d];
                  end
                  if (ordy[d]) done_cnt[d] <= post_cnt[d];
               end
            end else if (pending(d) && cyc > exp_cyc[d]) begin
               chk($sformatf("late_valid%0d", d),
                   {31'd0, ov[d]}, 32'd1);
            end
         end
      end
   end

   task automatic send(input int d, input int n,
                       input int gmin, input int gmax);
      logic [31:0] z;
      z = model_z(n);
      for (int i = 0; i < n; i++) begin
         iv[d] = 1'b1;
         ix[d] = to_fp(vx[i]);
         iw[d] = to_fp(vw[i]);
         ib[d] = (i == 0) ? to_fp(vb) : $urandom;
         @(posedge clk); #1;
         if (i == n - 1) begin
            exp_z[d] = z;
            exp_cyc[d] = cyc + 1;
            beats[d] = 0;
            post_cnt[d] = post_cnt[d] + 1;
         end else begin
            beats[d] = i + 1;
         end
         iv[d] = 1'b0;
         ix[d] = $urandom;
         iw[d] = $urandom;
         if (i < n - 1)
            repeat ($urandom_range(gmax, gmin)) begin
               @(posedge clk); #1;
            end
      end
   endtask

   task automatic wait_done(input int d, input int hold);
      int k;
      ordy[d] = 1'b0;
      iv[d] = 1'b1;
      ix[d] = $urandom;
      iw[d] = $urandom;
      ib[d] = $urandom;
      repeat (hold) begin
         @(posedge clk); #1;
      end
      ordy[d] = 1'b1;
      k = 0;
      while (pending(d) && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk($sformatf("drain_timeout%0d", d),
          {31'd0, pending(d)}, 32'd0);
      iv[d] = 1'b0;
      ordy[d] = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         iv[d] = 1'b0;
         ordy[d] = 1'b0;
         beats[d] = 0;
         post_cnt[d] = done_cnt[d];
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic partial(input int d);
      iv[d] = 1'b1;
      ix[d] = to_fp(7);
      iw[d] = to_fp(9);
      ib[d] = to_fp(-50);
      @(posedge clk); #1;
      beats[d] = 1;
      iv[d] = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         iv[d] = 1'b0;
         ordy[d] = 1'b0;
         ix[d] = 32'h0;
         iw[d] = 32'h0;
         ib[d] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_out_valid", {31'd0, ov[d]}, 32'd0);
         chk("rst_out_z", oz[d], 32'h0);
         chk("rst_busy", {31'd0, bz[d]}, 32'd0);
         chk("rst_in_ready", {31'd0, ir[d]}, 32'd1);
      end
      @(posedge clk); #1;

      vb = -30; vx[0] = 1; vx[1] = 1; vw[0] = 20; vw[1] = 20;
      chk("model_10", model_z(2), 32'h41200000);
      send(0, 2, 0, 0);
      wait_done(0, 0);

      vx[0] = 0;
      chk("model_m10", model_z(2), 32'hC1200000);
      send(0, 2, 0, 0);
      wait_done(0, 1);

      vx[0] = 1;
      send(0, 2, 3, 3);
      wait_done(0, 0);

      send(0, 2, 0, 1);
      wait_done(0, 5);

      partial(0);
      do_reset();
      vb = 5; vx[0] = 3; vx[1] = -2; vw[0] = 4; vw[1] = 7;
      chk("model_3", model_z(2), to_fp(3));
      send(0, 2, 0, 0);
      wait_done(0, 2);

      vb = 1; vx[0] = 2; vw[0] = 3;
      chk("model_7", model_z(1), 32'h40E00000);
      send(1, 1, 0, 0);
      wait_done(1, 0);

      send(0, 2, 0, 0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      do_reset();
      @(negedge clk);
      chk("hold_rst_valid", {31'd0, ov[0]}, 32'd0);
      chk("hold_rst_z", oz[0], 32'h0);
      @(posedge clk); #1;

      for (int t = 0; t < 60; t++) begin
         int d;
         int n;
         d = t % 2;
         n = (d == 0) ? 2 : 1;
         if (t % 13 == 5) begin
            partial(d);
            do_reset();
         end
         vb = int'($urandom_range(200)) - 100;
         for (int i = 0; i < n; i++) begin
            vx[i] = int'($urandom_range(16)) - 8;
            vw[i] = int'($urandom_range(16)) - 8;
         end
         send(d, n, 0, 3);
         wait_done(d, int'($urandom_range(3)));
      end

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
